// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter sharing one registered bitwise logic unit among NREQ requesters
module logic_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  input  logic [NREQ*2-1:0]     op_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      y,
  output logic [IDW-1:0]        y_id,
  output logic                  y_valid,
  input  logic                  y_ready
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state, state_nxt;
  logic [IDW-1:0] last, w, win, idx;
  logic [WIDTH-1:0] la, lb, res;
  logic [1:0] lop;
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last) + k) % NREQ);
      win = req[idx] ? idx : win;
    end
  end
  always_comb begin
    state_nxt = state == IDLE ? (|req ? EXEC : IDLE) :
                state == EXEC ? HOLD : (y_ready ? IDLE : HOLD);
    res = lop == 2'd0 ? la & lb : lop == 2'd1 ? la | lb : lop == 2'd2 ? la ^ lb : ~(la & lb);
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt <= '0;
      y <= '0;
      y_id <= '0;
      y_valid <= 1'b0;
      last <= IDW'(NREQ - 1);
      w <= '0;
      la <= '0;
      lb <= '0;
      lop <= '0;
    end else begin
      gnt <= '0;
      if (state == IDLE && |req) begin
        la <= a_in[win*WIDTH +: WIDTH];
        lb <= b_in[win*WIDTH +: WIDTH];
        lop <= op_in[win*2 +: 2];
        w <= win;
        last <= win;
        gnt <= NREQ'(1) << win;
      end
      if (state == EXEC) begin
        y <= res;
        y_id <= w;
        y_valid <= 1'b1;
      end
      if (state == HOLD && y_ready) y_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: randomized and directed checks against a transaction-level model
module tb_logic_unit_arbiter;
  logic clk = 0, rst_n = 0, y_ready = 0, busy, y_valid;
  logic [3:0] req = 0, gnt, g;
  logic [31:0] a_in = 0, b_in = 0;
  logic [7:0] op_in = 0, y, yv;
  logic [1:0] y_id;
  int n_vec = 0, n_err = 0, last = 3;
  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] sp_exp [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
  logic [7:0] op_exp [4] = '{8'h42, 8'hDB, 8'h99, 8'hBD};
  always #5 clk = ~clk;
  logic_unit_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .gnt(gnt), .busy(busy), .y(y), .y_id(y_id), .y_valid(y_valid), .y_ready(y_ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
    case (o)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction
  task automatic do_reset();
    req = 0;
    y_ready = 0;
    rst_n = 0;
    step();
    step();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", y_valid, 0);
    check("rst_y", y, 0);
    check("rst_id", y_id, 0);
    rst_n = 1;
    last = 3;
  endtask
  task automatic run_op(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] o, input int d, input logic [3:0] pend,
                        output logic [3:0] gs, output logic [7:0] ys);
    int w;
    logic [7:0] ey;
    w = pick(r);
    ey = alu(a[w*8 +: 8], b[w*8 +: 8], o[w*2 +: 2]);
    req = r;
    a_in = a;
    b_in = b;
    op_in = o;
    y_ready = 0;
    step();
    gs = gnt;
    check("gnt", gnt, 32'd1 << w);
    check("busy_gnt", busy, 1);
    check("valid_gnt", y_valid, 0);
    last = w;
    req = pend;
    a_in = $urandom;
    b_in = $urandom;
    op_in = 8'($urandom);
    y_ready = 1'($urandom_range(0, 1));
    step();
    ys = y;
    check("valid", y_valid, 1);
    check("y", y, ey);
    check("y_id", y_id, w);
    check("gnt_off", gnt, 0);
    for (int i = 0; i < d; i++) begin
      y_ready = 0;
      step();
      check("hold_y", y, ey);
      check("hold_id", y_id, w);
      check("hold_valid", y_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_gnt", gnt, 0);
    end
    y_ready = 1;
    step();
    check("done_valid", y_valid, 0);
    check("done_busy", busy, 0);
    check("done_gnt", gnt, 0);
    y_ready = 0;
  endtask
  initial begin
    step();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(4'b1111, $urandom, $urandom, 8'($urandom), 0, 4'b1111, g, yv);
      check("rr_order", g, rr_exp[i]);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_op(4'b1001, $urandom, $urandom, 8'($urandom), 0, 4'b1001, g, yv);
      check("sparse_order", g, sp_exp[i]);
    end
    for (int i = 0; i < 4; i++) begin
      run_op(4'b0010, 32'h0000C300, 32'h00005A00, 8'(i << 2), 1, 4'b0000, g, yv);
      check("opcode_y", yv, op_exp[i]);
    end
    run_op(4'b0001, $urandom, $urandom, 8'($urandom), 5, 4'b0100, g, yv);
    run_op(4'b0100, $urandom, $urandom, 8'($urandom), 0, 4'b0000, g, yv);
    check("bp_gnt2", g, 4'b0100);
    req = 4'b0100;
    a_in = $urandom;
    b_in = $urandom;
    step();
    req = 0;
    step();
    check("pre_rst_valid", y_valid, 1);
    do_reset();
    run_op(4'b1111, $urandom, $urandom, 8'($urandom), 0, 4'b0000, g, yv);
    check("post_rst_gnt", g, 4'b0001);
    for (int i = 0; i < 300; i++)
      run_op(4'($urandom_range(1, 15)), $urandom, $urandom, 8'($urandom),
             $urandom_range(0, 3), 4'($urandom), g, yv);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
